// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD A-B, LSD first; optional sign-magnitude via BCD_SUB_SIGN_MAG_EN
module bcd_serial_subtractor #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] DIFF,
  output logic                BORROW,
  output logic                NEG,
  output logic                ERR
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {IDLE, SUB, DONE, NEGATE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif
  state_t state, nstate;
  logic [W-1:0] a_r, b_r, acc, sh;
  logic [IW-1:0] idx;
  logic bin, bad, last, bout;
  logic [3:0] x, y, dig;
  logic [4:0] d;
  // flag any non-decimal nibble on the operands being accepted
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (A[4*i+:4] > 4'd9) | (B[4*i+:4] > 4'd9);
  end
  // one-digit BCD subtract; the negate pass reuses it as 0 - acc
  always_comb begin
`ifdef BCD_SUB_SIGN_MAG_EN
    x = state == NEGATE ? 4'd0 : a_r[3:0];
    y = state == NEGATE ? acc[3:0] : b_r[3:0];
`else
    x = a_r[3:0];
    y = b_r[3:0];
`endif
    d = {1'b0, x} - {1'b0, y} - {4'd0, bin};
    bout = d[4];
    dig = bout ? d[3:0] + 4'd10 : d[3:0];
    sh = W'({dig, acc} >> 4);
    last = idx == IW'(DIGITS - 1);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nstate;
  end
  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = start ? (bad ? DONE : SUB) : IDLE;
`ifdef BCD_SUB_SIGN_MAG_EN
      SUB: nstate = last ? (bout ? NEGATE : DONE) : SUB;
      NEGATE: nstate = last ? DONE : NEGATE;
`else
      SUB: nstate = last ? DONE : SUB;
`endif
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
`ifdef BCD_SUB_SIGN_MAG_EN
  assign busy = state == SUB || state == NEGATE;
`else
  assign busy = state == SUB;
  assign NEG = 1'b0;
`endif
  assign done = state == DONE;
  // operand shifting, borrow chain, and result capture on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      idx <= '0;
      bin <= 1'b0;
      DIFF <= '0;
      BORROW <= 1'b0;
      ERR <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      NEG <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_r <= A;
      b_r <= B;
      idx <= '0;
      bin <= 1'b0;
      if (bad) begin
        DIFF <= '0;
        BORROW <= 1'b0;
        ERR <= 1'b1;
`ifdef BCD_SUB_SIGN_MAG_EN
        NEG <= 1'b0;
`endif
      end
    end else if (busy) begin
      a_r <= a_r >> 4;
      b_r <= b_r >> 4;
      acc <= sh;
      bin <= last ? 1'b0 : bout;
      idx <= last ? '0 : idx + 1'b1;
      if (last && nstate == DONE) begin
        DIFF <= sh;
        BORROW <= state == SUB ? bout : 1'b1;
        ERR <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
        NEG <= state != SUB;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: directed vectors with queued expectations checked by a done-driven monitor
module tb_bcd_serial_subtractor;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] A = 0, B = 0, DIFF;
  logic busy, done, BORROW, NEG, ERR;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] prev = 0;
`ifdef BCD_SUB_SIGN_MAG_EN
  localparam bit SM = 1;
`else
  localparam bit SM = 0;
`endif
  typedef struct {logic [7:0] diff; logic b, n, e; int lat, st;} exp_t;
  exp_t q[$];

  bcd_serial_subtractor #(.DIGITS(2)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .DIFF(DIFF), .BORROW(BORROW), .NEG(NEG), .ERR(ERR));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_done: DIFF=%h BORROW=%b ERR=%b with nothing expected", DIFF, BORROW, ERR);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({DIFF, BORROW, NEG, ERR} !== {e.diff, e.b, e.n, e.e}) begin
          bad++;
          $display("FAIL result: got DIFF=%h B=%b N=%b E=%b want DIFF=%h B=%b N=%b E=%b",
                   DIFF, BORROW, NEG, ERR, e.diff, e.b, e.n, e.e);
        end
        total++;
        if (cyc - e.st != e.lat) begin
          bad++;
          $display("FAIL latency: got %0d want %0d", cyc - e.st, e.lat);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen, got 0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] df,
                     input logic br, input logic ng, input logic er, input int lat);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1;
    e.diff = df; e.b = br; e.n = ng; e.e = er; e.lat = lat; e.st = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 0;
    if (!er) begin
      chk("busy", {15'd0, busy}, 16'd1);
      chk("diff_hold", {8'd0, DIFF}, {8'd0, prev});
    end
    prev = df;
    wait_done();
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_state", {10'd0, busy, done, BORROW, NEG, ERR, 1'b0}, 16'd0);
    chk("reset_diff", {8'd0, DIFF}, 16'd0);
    run(8'h45, 8'h23, 8'h22, 0, 0, 0, 3);
    run(8'h10, 8'h01, 8'h09, 0, 0, 0, 3);
    run(8'h23, 8'h45, SM ? 8'h22 : 8'h78, 1, SM, 0, SM ? 5 : 3);
    run(8'h4A, 8'h11, 8'h00, 0, 0, 1, 1);
    run(8'h99, 8'h99, 8'h00, 0, 0, 0, 3);
    run(8'h99, 8'h00, 8'h99, 0, 0, 0, 3);
    run(8'h00, 8'h01, SM ? 8'h01 : 8'h99, 1, SM, 0, SM ? 5 : 3);
    run(8'h12, 8'hF0, 8'h00, 0, 0, 1, 1);
    run(8'h50, 8'h05, 8'h45, 0, 0, 0, 3);
    @(negedge clk);
    A = 8'h45;
    B = 8'h23;
    start = 1;
    e.diff = 8'h22; e.b = 0; e.n = 0; e.e = 0; e.lat = 3; e.st = cyc;
    q.push_back(e);
    @(negedge clk);
    A = 8'h99;
    B = 8'h00;
    @(negedge clk);
    start = 0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    @(negedge clk);
    A = 8'h45;
    B = 8'h23;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_state", {10'd0, busy, done, BORROW, NEG, ERR, 1'b0}, 16'd0);
    chk("abort_diff", {8'd0, DIFF}, 16'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", {15'd0, done}, 16'd0);
    prev = 8'h00;
    run(8'h00, 8'h99, SM ? 8'h99 : 8'h01, 1, SM, 0, SM ? 5 : 3);
    repeat (3) @(negedge clk);
    chk("final_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
